// File: rtl/segasys1_timing_pkg.sv
// segasys1_timing_pkg: default raster constants shared by the video timing block.
// Holds the default divider and raster geometry plus the counter widths.
package segasys1_timing_pkg;
   localparam int PIX_W        = 9;
   localparam int FRAME_W      = 8;
   localparam int DEF_CLK_DIV  = 8;
   localparam int DEF_H_TOTAL  = 384;
   localparam int DEF_H_ACTIVE = 256;
   localparam int DEF_HS_START = 304;
   localparam int DEF_HS_WIDTH = 32;
   localparam int DEF_V_TOTAL  = 264;
   localparam int DEF_V_ACTIVE = 224;
   localparam int DEF_VS_START = 240;
   localparam int DEF_VS_WIDTH = 3;
endpackage

// File: rtl/segasys1_mod_counter.sv
// segasys1_mod_counter: enabled modulo-LIMIT counter with carry-out.
// Ports: clk_i clock, rst_n_i async active-low reset, en_i count enable,
//        q_o current count, carry_o high when enabled at LIMIT-1 (wrap edge).
module segasys1_mod_counter #(
   parameter int W     = 9,
   parameter int LIMIT = 384
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   output logic [W-1:0] q_o,
   output logic         carry_o
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      carry_o = en_i && (cnt_q == W'(LIMIT - 1));
      cnt_d   = !en_i ? cnt_q : carry_o ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   assign q_o = cnt_q;
endmodule

// File: rtl/segasys1_video_timing.sv
// segasys1_video_timing: raster timing generator (pixel enable, PH/PV, blank, sync, frame).
// Ports: clk48M clock, reset_n async active-low reset, PCLK_EN pixel enable,
//        PH/PV pixel/line counters, HBLK/VBLK blanking, HSYNC/VSYNC syncs,
//        VBLK_RISE one-cycle strobe at vertical-blank start, FRAME frame counter.
module segasys1_video_timing
   import segasys1_timing_pkg::*;
#(
   parameter int CLK_DIV  = DEF_CLK_DIV,
   parameter int H_TOTAL  = DEF_H_TOTAL,
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_WIDTH = DEF_HS_WIDTH,
   parameter int V_TOTAL  = DEF_V_TOTAL,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int VS_START = DEF_VS_START,
   parameter int VS_WIDTH = DEF_VS_WIDTH
) (
   input  logic               clk48M,
   input  logic               reset_n,
   output logic               PCLK_EN,
   output logic [PIX_W-1:0]   PH,
   output logic [PIX_W-1:0]   PV,
   output logic               HBLK,
   output logic               VBLK,
   output logic               HSYNC,
   output logic               VSYNC,
   output logic               VBLK_RISE,
   output logic [FRAME_W-1:0] FRAME
);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [PIX_W:0] HS_END = (PIX_W+1)'(HS_START + HS_WIDTH);
   localparam logic [PIX_W:0] VS_END = (PIX_W+1)'(VS_START + VS_WIDTH);

   if (!(H_ACTIVE < H_TOTAL && HS_START + HS_WIDTH <= H_TOTAL && V_ACTIVE < V_TOTAL &&
         VS_START + VS_WIDTH <= V_TOTAL && CLK_DIV >= 2 && H_TOTAL <= 512 && V_TOTAL <= 512))
   begin : g_bad_timing
      $fatal(1, "segasys1_video_timing: inconsistent timing parameters");
   end

   logic [DIV_W-1:0]   div_q;
   logic [PIX_W-1:0]   ph_q, pv_q, ph_d, pv_d;
   logic               div_wrap, ph_wrap, pv_wrap;
   logic               hblk_q, vblk_q, hsync_q, vsync_q, vblk_rise_q;
   logic [FRAME_W-1:0] frame_q;

   segasys1_mod_counter #(.W(DIV_W), .LIMIT(CLK_DIV)) u_div (
      .clk_i(clk48M), .rst_n_i(reset_n), .en_i(1'b1), .q_o(div_q), .carry_o(div_wrap));
   segasys1_mod_counter #(.W(PIX_W), .LIMIT(H_TOTAL)) u_ph (
      .clk_i(clk48M), .rst_n_i(reset_n), .en_i(div_wrap), .q_o(ph_q), .carry_o(ph_wrap));
   segasys1_mod_counter #(.W(PIX_W), .LIMIT(V_TOTAL)) u_pv (
      .clk_i(clk48M), .rst_n_i(reset_n), .en_i(ph_wrap), .q_o(pv_q), .carry_o(pv_wrap));

   // Post-edge counter values so the registered decodes line up with PH/PV.
   always_comb begin
      ph_d = ph_wrap ? '0 : ph_q + 1'b1;
      pv_d = pv_wrap ? '0 : ph_wrap ? pv_q + 1'b1 : pv_q;
   end

   always_ff @(posedge clk48M or negedge reset_n)
      if (!reset_n) begin
         hblk_q      <= 1'b0;
         vblk_q      <= 1'b0;
         hsync_q     <= 1'b0;
         vsync_q     <= 1'b0;
         vblk_rise_q <= 1'b0;
         frame_q     <= '0;
      end else begin
         vblk_rise_q <= ph_wrap && (pv_q == PIX_W'(V_ACTIVE - 1));
         if (div_wrap) begin
            hblk_q  <= ph_d >= PIX_W'(H_ACTIVE);
            vblk_q  <= pv_d >= PIX_W'(V_ACTIVE);
            hsync_q <= (ph_d >= PIX_W'(HS_START)) && ({1'b0, ph_d} < HS_END);
            vsync_q <= (pv_d >= PIX_W'(VS_START)) && ({1'b0, pv_d} < VS_END);
         end
         if (pv_wrap) frame_q <= frame_q + 1'b1;
      end

   assign PCLK_EN   = div_q == DIV_W'(CLK_DIV - 1);
   assign PH        = ph_q;
   assign PV        = pv_q;
   assign HBLK      = hblk_q;
   assign VBLK      = vblk_q;
   assign HSYNC     = hsync_q;
   assign VSYNC     = vsync_q;
   assign VBLK_RISE = vblk_rise_q;
   assign FRAME     = frame_q;
endmodule
